fc2_argmax: RTL and testbench

FC2_ARGMAX -- requirements
Module: fc2_argmax

---
 rtl/mnist_pkg.sv | 21 ++
 rtl/mac_lane.sv | 44 ++++
 rtl/fc2_argmax.sv | 126 ++++++++++++
 tb/tb_fc2_argmax.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/mnist_pkg.sv
// Shared sizes and FSM state encoding for the MNIST FC2 + argmax datapath.
package mnist_pkg;

   localparam int unsigned N_IN   = 32;
   localparam int unsigned N_OUT  = 10;
   localparam int unsigned W_WT   = 8;
   localparam int unsigned W_ACC  = 48;
   localparam int unsigned W_R    = 32;
   localparam int unsigned W_PROD = W_R + W_WT;
   localparam int unsigned W_CNT  = 5;
   localparam int unsigned W_DIG  = 4;

   typedef enum logic [2:0] {
      IDLE,
      MAC,
      DRAIN,
      ARGMAX,
      DONE
   } state_t;

endpackage

// File: rtl/mac_lane.sv
// One signed multiply-accumulate lane with synchronous clear.
module mac_lane
   import mnist_pkg::*;
#(
   parameter int unsigned W_A = W_R,
   parameter int unsigned W_B = W_WT,
   parameter int unsigned W_S = W_ACC
) (
   input  logic           clk,
   input  logic           resetn,
   input  logic           i_clr,
   input  logic           i_en,
   input  logic [W_A-1:0] i_a,
   input  logic [W_B-1:0] i_b,
   output logic [W_S-1:0] o_acc
);

   localparam int unsigned W_P = W_A + W_B;

   logic signed [W_P-1:0] w_a_ext;
   logic signed [W_P-1:0] w_b_ext;
   logic signed [W_P-1:0] w_prod;
   logic signed [W_S-1:0] w_prod_ext;
   logic        [W_S-1:0] r_acc;

   // Both operands widened to the full product width so the multiply is exact.
   assign w_a_ext    = W_P'($signed(i_a));
   assign w_b_ext    = W_P'($signed(i_b));
   assign w_prod     = w_a_ext * w_b_ext;
   assign w_prod_ext = W_S'(w_prod);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_acc <= '0;
      end else if (i_clr) begin
         r_acc <= '0;
      end else if (i_en) begin
         r_acc <= r_acc + w_prod_ext;
      end
   end

   assign o_acc = r_acc;

endmodule

// File: rtl/fc2_argmax.sv
// FC2 layer (N_IN x N_OUT signed MACs) followed by a sequential argmax over the class scores.
module fc2_argmax
   import mnist_pkg::*;
#(
   parameter int unsigned N_IN  = mnist_pkg::N_IN,
   parameter int unsigned N_OUT = mnist_pkg::N_OUT,
   parameter int unsigned W_WT  = mnist_pkg::W_WT,
   parameter int unsigned W_ACC = mnist_pkg::W_ACC
) (
   input  logic                    clk,
   input  logic                    resetn,
   input  logic                    start,
   output logic                    busy,
   output logic [W_CNT-1:0]        counter,
   input  logic [W_R-1:0]          r,
   output logic [W_CNT-1:0]        wt_addr,
   input  logic [N_OUT*W_WT-1:0]   wt_data,
   output logic                    done,
   output logic [W_DIG-1:0]        digit,
   output logic [W_ACC-1:0]        score
);

   state_t                   r_state;
   logic [W_R-1:0]           r_q;
   logic                     r_acc_en;
   logic [W_DIG-1:0]         r_idx;
   logic [W_DIG-1:0]         r_best_idx;
   logic signed [W_ACC-1:0]  r_best_val;

   logic                     w_clr;
   logic [W_ACC-1:0]         w_acc [N_OUT];
   logic signed [W_ACC-1:0]  w_cand;
   logic                     w_take;
   logic [W_DIG-1:0]         w_nxt_idx;
   logic signed [W_ACC-1:0]  w_nxt_val;

   assign w_clr   = (r_state == IDLE) && start;
   assign wt_addr = counter;

   // r_q pairs with wt_data one cycle later, since the ROM row lags wt_addr by a cycle.
   for (genvar k = 0; k < N_OUT; k++) begin : g_lane
      mac_lane #(
         .W_A (W_R),
         .W_B (W_WT),
         .W_S (W_ACC)
      ) u_lane (
         .clk    (clk),
         .resetn (resetn),
         .i_clr  (w_clr),
         .i_en   (r_acc_en),
         .i_a    (r_q),
         .i_b    (wt_data[k*W_WT +: W_WT]),
         .o_acc  (w_acc[k])
      );
   end

   // Strictly-greater replacement keeps the lowest index on ties.
   assign w_cand    = $signed(w_acc[r_idx]);
   assign w_take    = (r_idx == '0) || (w_cand > r_best_val);
   assign w_nxt_idx = w_take ? r_idx  : r_best_idx;
   assign w_nxt_val = w_take ? w_cand : r_best_val;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state    <= IDLE;
         busy       <= 1'b0;
         counter    <= '0;
         done       <= 1'b0;
         digit      <= '0;
         score      <= '0;
         r_q        <= '0;
         r_acc_en   <= 1'b0;
         r_idx      <= '0;
         r_best_idx <= '0;
         r_best_val <= '0;
      end else begin
         done     <= 1'b0;
         r_acc_en <= 1'b0;
         case (r_state)
            IDLE: begin
               counter <= '0;
               if (start) begin
                  r_state <= MAC;
                  busy    <= 1'b1;
               end
            end
            MAC: begin
               r_q      <= r;
               r_acc_en <= 1'b1;
               if (counter == W_CNT'(N_IN - 1)) begin
                  counter <= '0;
                  r_state <= DRAIN;
               end else begin
                  counter <= counter + W_CNT'(1);
               end
            end
            DRAIN: begin
               r_idx   <= '0;
               r_state <= ARGMAX;
            end
            ARGMAX: begin
               r_best_idx <= w_nxt_idx;
               r_best_val <= w_nxt_val;
               if (r_idx == W_DIG'(N_OUT - 1)) begin
                  r_idx   <= '0;
                  digit   <= w_nxt_idx;
                  score   <= w_nxt_val;
                  done    <= 1'b1;
                  r_state <= DONE;
               end else begin
                  r_idx <= r_idx + W_DIG'(1);
               end
            end
            DONE: begin
               busy    <= 1'b0;
               r_state <= IDLE;
            end
            default: begin
               busy    <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fc2_argmax.sv
// Scoreboard bench for fc2_argmax: directed activation/weight patterns with hand-computed winners.
module tb_fc2_argmax;

   localparam int M_RAMP    = 0;
   localparam int M_TIE     = 1;
   localparam int M_EXTREME = 2;
   localparam int M_ONEHOT  = 3;

   logic        clk    = 1'b0;
   logic        resetn = 1'b0;
   logic        start  = 1'b0;
   logic        busy;
   logic [4:0]  counter;
   logic [31:0] r;
   logic [4:0]  wt_addr;
   logic [79:0] wt_data = '0;
   logic        done;
   logic [3:0]  digit;
   logic [47:0] score;

   typedef struct {
      logic [3:0]  d;
      logic [47:0] s;
      int          c;
   } exp_t;

   exp_t q[$];
   exp_t e_mon;
   int   n_chk = 0;
   int   n_fail = 0;
   int   cyc = 0;
   int   mode = M_RAMP;

   fc2_argmax dut (
      .clk     (clk),
      .resetn  (resetn),
      .start   (start),
      .busy    (busy),
      .counter (counter),
      .r       (r),
      .wt_addr (wt_addr),
      .wt_data (wt_data),
      .done    (done),
      .digit   (digit),
      .score   (score)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Activation source: combinational in counter.
   always_comb begin
      case (mode)
         M_RAMP:    r = 32'd1;
         M_TIE:     r = 32'd5;
         M_EXTREME: r = 32'h7FFF_FFFF;
         M_ONEHOT:  r = 32'(counter);
         default:   r = 32'd0;
      endcase
   end

   function automatic logic [7:0] lane_w(input int m, input int k, input logic [4:0] a);
      case (m)
         M_RAMP:    return 8'(k);
         M_TIE:     return 8'd0;
         M_EXTREME: return (k == 5) ? 8'h7F : 8'h80;
         M_ONEHOT:  return ((int'(a) % 10) == k) ? 8'd1 : 8'd0;
         default:   return 8'd0;
      endcase
   endfunction

   // Weight ROM with one cycle of read latency.
   always @(posedge clk) begin
      for (int k = 0; k < 10; k++) wt_data[k*8 +: 8] <= lane_w(mode, k, wt_addr);
   end

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (resetn && done) begin
         if (q.size() == 0) begin
            check("unexpected_done", 64'(done), 64'd0);
         end else begin
            e_mon = q.pop_front();
            check("digit", 64'(digit), 64'(e_mon.d));
            check("score", 64'(score), 64'(e_mon.s));
            check("done_cycle", 64'(cyc), 64'(e_mon.c));
         end
      end
   end

   task automatic issue(input logic [3:0] d, input logic [47:0] s, input bit expect_done);
      exp_t e;
      @(negedge clk);
      start = 1'b1;
      if (expect_done) begin
         e.d = d;
         e.s = s;
         e.c = cyc + 44;
         q.push_back(e);
      end
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_all(input int budget);
      for (int i = 0; i < budget && q.size() != 0; i++) @(negedge clk);
      if (q.size() != 0) begin
         check("done_timeout", 64'(q.size()), 64'd0);
         q.delete();
      end
   endtask

   task automatic run(input int m, input logic [3:0] d, input logic [47:0] s, input bit chk_cnt);
      bit ok;
      mode = m;
      issue(d, s, 1'b1);
      if (chk_cnt) begin
         ok = 1'b1;
         for (int i = 0; i < 32; i++) begin
            if (i > 0) @(negedge clk);
            if (counter != 5'(i) || wt_addr != counter || !busy) ok = 1'b0;
         end
         check("counter_seq", 64'(ok), 64'd1);
         @(negedge clk);
         check("counter_after_mac", 64'(counter), 64'd0);
      end
      wait_all(120);
      @(negedge clk);
      check("busy_idle", 64'(busy), 64'd0);
   endtask

   initial begin
      int base;
      exp_t e;

      // Reset
      repeat (3) @(negedge clk);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_counter", 64'(counter), 64'd0);
      check("rst_digit", 64'(digit), 64'd0);
      check("rst_score", 64'(score), 64'd0);
      resetn = 1'b1;
      repeat (2) @(negedge clk);

      run(M_RAMP,    4'd9, 48'd288,           1'b1);
      run(M_TIE,     4'd0, 48'd0,             1'b0);
      run(M_EXTREME, 4'd5, 48'd8727373541408, 1'b0);
      run(M_ONEHOT,  4'd1, 48'd64,            1'b0);

      // Abort: second start ignored, reset mid-inference, no done
      mode = M_TIE;
      issue(4'd0, 48'd0, 1'b0);
      repeat (8) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      resetn = 1'b0;
      #1;
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_done", 64'(done), 64'd0);
      check("abort_counter", 64'(counter), 64'd0);
      check("abort_score", 64'(score), 64'd0);
      repeat (3) @(negedge clk);
      resetn = 1'b1;
      repeat (2) @(negedge clk);
      run(M_RAMP, 4'd9, 48'd288, 1'b0);

      // Continuous start: three back-to-back inferences
      mode = M_RAMP;
      @(negedge clk);
      start = 1'b1;
      base = cyc;
      for (int i = 0; i < 3; i++) begin
         e.d = 4'd9;
         e.s = 48'd288;
         e.c = base + 44 + 45 * i;
         q.push_back(e);
      end
      repeat (100) @(negedge clk);
      start = 1'b0;
      wait_all(200);
      repeat (4) @(negedge clk);
      check("queue_empty", 64'(q.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

endmodule
